// File: rtl/b1_scfifo_pkg.sv
// -----------------------------------------------------------------------------
// b1_scfifo_pkg
//   Constants and types shared by the b1_scfifo core and the blocks that sit
//   around it.
//   - SHOWAHEAD_ON / SHOWAHEAD_OFF : legal values of the SHOWAHEAD parameter.
//   - B1_SCFIFO_DWIDTH             : default data word width of the FIFO family.
//   - occ_e                        : occupancy of the 2-entry output buffer.
// -----------------------------------------------------------------------------
package b1_scfifo_pkg;

  // "ON": q is valid while !empty and rdreq pops it.
  // "OFF": q is valid one cycle after rdreq.
  localparam string SHOWAHEAD_ON  = "ON";
  localparam string SHOWAHEAD_OFF = "OFF";

  localparam int B1_SCFIFO_DWIDTH = 8;

  // The encoding equals the number of stored words, so the value can be used
  // directly in occupancy arithmetic.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage : b1_scfifo_pkg

// File: rtl/b1_skid_buf2.sv
// -----------------------------------------------------------------------------
// b1_skid_buf2
//   Two-entry register FIFO. buf0 is always the head, so the head word is a
//   flop output with no combinational path from push/pop.
//
// Ports
//   clk_i        in   clock, rising edge
//   arst_i       in   asynchronous active-high reset
//   push_i       in   write push_data_i this cycle (ignored when full)
//   push_data_i  in   DWIDTH  word to write
//   pop_i        in   remove the head this cycle (only legal when not empty)
//   head_o       out  DWIDTH  current head word
//   occ_o        out  occ_e   number of stored words (0..2)
// -----------------------------------------------------------------------------
module b1_skid_buf2
  import b1_scfifo_pkg::*;
#(
  parameter int DWIDTH = B1_SCFIFO_DWIDTH
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              push_i,
  input  logic [DWIDTH-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DWIDTH-1:0] head_o,
  output occ_e              occ_o
);

  logic [DWIDTH-1:0] buf0_q, buf0_d;
  logic [DWIDTH-1:0] buf1_q, buf1_d;
  occ_e              occ_q,  occ_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = occ_q;

    case ({push_i, pop_i})
      2'b10: begin
        case (occ_q)
          OCC_EMPTY: begin
            buf0_d = push_data_i;
            occ_d  = OCC_ONE;
          end
          OCC_ONE: begin
            buf1_d = push_data_i;
            occ_d  = OCC_TWO;
          end
          default: ; // full: the caller never pushes here
        endcase
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = (occ_q == OCC_TWO) ? OCC_ONE : OCC_EMPTY;
      end
      2'b11: begin
        // Occupancy is unchanged; the head advances to the next word in line,
        // which is buf1 when full and the incoming word otherwise.
        if (occ_q == OCC_TWO) begin
          buf0_d = buf1_q;
          buf1_d = push_data_i;
        end else begin
          buf0_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  // NOTE: the two data registers are reset even though occupancy alone says
  // which entries are meaningful; the head drives data_o directly and that
  // output must read 0 while in reset.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      buf0_q <= '0;
      buf1_q <= '0;
      occ_q  <= OCC_EMPTY;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the
      // pre-edge values computed above, independent of statement order.
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
      occ_q  <= occ_d;
    end
  end

  assign head_o = buf0_q;
  assign occ_o  = occ_q;

endmodule : b1_skid_buf2

// File: rtl/b1_scfifo_stream_rd.sv
// -----------------------------------------------------------------------------
// b1_scfifo_stream_rd
//   Drains a b1_scfifo onto a valid/ready stream and frames the words into
//   fixed-length packets marked with sop/eop. Works with either SHOWAHEAD mode
//   of the FIFO and sustains one word per clock under continuous ready.
//
// Ports
//   clk_i         in   clock, rising edge
//   arst_i        in   asynchronous active-high reset
//   fifo_empty_i  in   FIFO empty flag
//   fifo_q_i      in   DWIDTH  FIFO read data
//   fifo_rdreq_o  out  FIFO read request
//   data_o        out  DWIDTH  stream data
//   valid_o       out  stream word valid
//   sop_o         out  first word of a packet (qualified by valid_o)
//   eop_o         out  last word of a packet (qualified by valid_o)
//   ready_i       in   downstream accepts when valid_o && ready_i
//   word_cnt_o    out  CWIDTH  words of the current packet already sent
// -----------------------------------------------------------------------------
module b1_scfifo_stream_rd
  import b1_scfifo_pkg::*;
#(
  parameter int    DWIDTH    = B1_SCFIFO_DWIDTH,
  parameter string SHOWAHEAD = SHOWAHEAD_ON,
  parameter int    PKT_LEN   = 16,
  parameter int    CWIDTH    = $clog2(PKT_LEN + 1)
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              fifo_empty_i,
  input  logic [DWIDTH-1:0] fifo_q_i,
  output logic              fifo_rdreq_o,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  output logic              sop_o,
  output logic              eop_o,
  input  logic              ready_i,
  output logic [CWIDTH-1:0] word_cnt_o
);

  localparam bit                SHOW_ON  = (SHOWAHEAD == SHOWAHEAD_ON);
  localparam logic [CWIDTH-1:0] CNT_LAST = CWIDTH'(PKT_LEN - 1);

  occ_e              occ;
  logic [DWIDTH-1:0] head;
  logic              pop;
  logic              push;
  logic [1:0]        committed;

  logic              in_flight_q, in_flight_d;
  logic [CWIDTH-1:0] word_cnt_q,  word_cnt_d;

  // ---------------------------------------------------------------------------
  // Output buffer
  // ---------------------------------------------------------------------------
  b1_skid_buf2 #(
    .DWIDTH (DWIDTH)
  ) u_buf (
    .clk_i       (clk_i),
    .arst_i      (arst_i),
    .push_i      (push),
    .push_data_i (fifo_q_i),
    .pop_i       (pop),
    .head_o      (head),
    .occ_o       (occ)
  );

  assign valid_o = (occ != OCC_EMPTY);
  assign data_o  = head;
  assign pop     = valid_o && ready_i;

  // ---------------------------------------------------------------------------
  // Read issue
  // ---------------------------------------------------------------------------
  // Words already owned after this edge: what stays in the buffer plus the
  // word still in flight from the FIFO. A new read is issued only while that
  // leaves room, which keeps the buffer from ever overrunning. Using the pop
  // of this same cycle is what lets a full buffer keep streaming.
  always_comb begin
    committed    = occ - {1'b0, pop} + {1'b0, in_flight_q};
    // While in reset the buffer looks empty, so the read must be masked
    // explicitly to keep the FIFO untouched.
    fifo_rdreq_o = !arst_i && !fifo_empty_i && (committed < 2'd2);
  end

  // In showahead mode the word is on fifo_q_i in the same cycle as the read;
  // otherwise it arrives one cycle later, tracked by in_flight.
  always_comb begin
    if (SHOW_ON) begin
      push        = fifo_rdreq_o;
      in_flight_d = 1'b0;
    end else begin
      push        = in_flight_q;
      in_flight_d = fifo_rdreq_o;
    end
  end

  // ---------------------------------------------------------------------------
  // Packet framing
  // ---------------------------------------------------------------------------
  always_comb begin
    word_cnt_d = word_cnt_q;
    if (pop) begin
      word_cnt_d = (word_cnt_q == CNT_LAST) ? '0 : word_cnt_q + CWIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      in_flight_q <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      in_flight_q <= in_flight_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  // Built only from flops, so they hold still during a stall.
  assign sop_o      = valid_o && (word_cnt_q == '0);
  assign eop_o      = valid_o && (word_cnt_q == CNT_LAST);
  assign word_cnt_o = word_cnt_q;

endmodule : b1_scfifo_stream_rd

// File: doc/b1_scfifo_stream_rd.md
Name: b1_scfifo_stream_rd

Overview:
- Drains a b1_scfifo core onto a valid/ready output stream and frames the words into fixed-length packets with sop/eop markers.
- Sits directly downstream of the FIFO. Takes its empty_o/q_o and drives its rdreq_i.
- Supports both SHOWAHEAD modes of the FIFO.
- A 2-entry output buffer gives full throughput under ready_i backpressure.

Parameters:
- DWIDTH, 8, data word width; must match the FIFO.
- SHOWAHEAD, "ON", FIFO read mode. "ON": q_i is valid while !empty_i and rdreq_o pops it. "OFF": q_i is valid one cycle after rdreq_o.
- PKT_LEN, 16, words per packet, ≥1.
- CWIDTH, $clog2(PKT_LEN+1), width of the packet word counter.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- arst_i  in  1  asynchronous, active-high reset.
- fifo_empty_i  in  1  FIFO empty_o.
- fifo_q_i  in  DWIDTH  FIFO q_o.
- fifo_rdreq_o  out  1  FIFO rdreq_i.
- data_o  out  DWIDTH  stream data.
- valid_o  out  1  stream word valid.
- sop_o  out  1  first word of a packet; qualified by valid_o.
- eop_o  out  1  last word of a packet; qualified by valid_o.
- ready_i  in  1  downstream accepts the word when valid_o && ready_i.
- word_cnt_o  out  CWIDTH  words of the current packet already transferred.

Behaviour:
- Reset: asynchronous assert, synchronous deassert is assumed upstream. While arst_i=1 all outputs are 0, the buffer is empty, in_flight=0 and word_cnt=0.
- Buffer: 2-entry register FIFO (buf[0]=head, buf[1]). occupancy is 0..2.
- Output path: valid_o = (occupancy>0), data_o = buf[0]. A transfer is valid_o && ready_i. Output registers are driven straight from the buffer, with no combinational path from ready_i to data_o.
- Read issue rule: fifo_rdreq_o = !fifo_empty_i && (occupancy - pop + in_flight) < 2, where pop = valid_o && ready_i.
  - The rule never overruns the buffer.
  - fifo_rdreq_o is never asserted while fifo_empty_i=1.
  - It may depend combinationally on ready_i.
- SHOWAHEAD="ON": on a cycle with fifo_rdreq_o=1, fifo_q_i is written into the buffer at that clock edge. in_flight is always 0.
- SHOWAHEAD="OFF": in_flight <= fifo_rdreq_o. When in_flight=1, fifo_q_i is written into the buffer at that edge.
- Simultaneous push and pop:
  - occupancy is unchanged.
  - The head shifts: buf[0] <= buf[1] when occupancy=2, otherwise buf[0] <= the incoming word.
- Steady state: when the FIFO is non-empty and ready_i=1 constantly, the block sustains one word per clock in both modes.
- Framing:
  - sop_o = valid_o && (word_cnt==0).
  - eop_o = valid_o && (word_cnt==PKT_LEN-1).
  - On each transfer word_cnt increments. It wraps to 0 on the transfer where eop_o=1.
  - With PKT_LEN=1, sop_o and eop_o are both 1 on every word.
- Stall rule: while valid_o=1 && ready_i=0, data_o, sop_o and eop_o hold stable.
- FIFO empty mid-packet: valid_o drops once the buffer drains. word_cnt holds and framing resumes at the next word; no padding is inserted.
- Reset mid-packet: the partial packet is discarded and word_cnt=0. The next word after reset carries sop_o=1.
- Word counts:
  - Number of FIFO pops = words written into the buffer (SHOWAHEAD="OFF": one cycle later).
  - Words are never dropped or duplicated.

Decomposition:
- Package b1_scfifo_pkg holds the SHOWAHEAD string constants ("ON"/"OFF") and the shared DWIDTH default, reused by b1_scfifo and this block.
- Sub-module b1_skid_buf2: the 2-entry buffer with push/pop/occupancy.
- The top level holds the read-issue logic, in_flight and framing counter.

Test Plan:
- Reset: assert arst_i mid-clock → all outputs 0 immediately, without waiting for a clock edge. Release, then push 3 words → first word out has sop_o=1.
- Streaming, SHOWAHEAD="ON", PKT_LEN=4: FIFO holds 0x10..0x17, ready_i=1 → data_o 0x10..0x17 on 8 consecutive cycles. sop_o on 0x10 and 0x14, eop_o on 0x13 and 0x17.
- Same stimulus with SHOWAHEAD="OFF" → identical sequence, first valid_o one cycle later, then no bubbles.
- Backpressure: ready_i toggles 1,0,0,1 with FIFO holding 0xA0..0xA9 → every word is delivered exactly once, in order. data_o is stable during stalls. fifo_rdreq_o is never 1 when occupancy+in_flight=2 and there is no pop.
- Underflow: FIFO goes empty after 2 words of a PKT_LEN=4 packet. 5 idle cycles, then 2 more words → eop_o on the 4th word and word_cnt_o sequence 0,1,2,3. fifo_rdreq_o=0 whenever fifo_empty_i=1.
- Reset mid-packet: after 2 words of PKT_LEN=4, pulse arst_i → word_cnt_o=0 and the next delivered word has sop_o=1.
